// File: rtl/out_check_pkg.sv
// Shared types and width helpers for the out-channel checker.
package out_check_pkg;

    typedef enum logic [1:0] {
        RUN,
        PASS,
        FAIL
    } state_e;

    function automatic int recv_w(input int n);
        return $clog2(n + 2);
    endfunction

    function automatic int midx_w(input int n);
        return $clog2(n + 1);
    endfunction

    function automatic int step_w(input int m);
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/out_fifo.sv
// Capture FIFO: wrap-bit pointers, same-cycle push/pop, registered storage.
module out_fifo #(
    parameter int Width = 12,
    parameter int Depth = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [Width-1:0] data_i,
    output logic [Width-1:0] head_o,
    output logic             empty_o,
    output logic             full_next_o
);

    localparam int AW = $clog2(Depth);

    logic [AW:0]      wptr_q, wptr_d;
    logic [AW:0]      rptr_q, rptr_d;
    logic [Width-1:0] mem_q [Depth];
    logic             full;
    logic             do_push;
    logic             do_pop;

    assign empty_o = (wptr_q == rptr_q);
    assign full    = (wptr_q[AW] != rptr_q[AW]) &&
                     (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign do_pop  = pop_i && !empty_o;
    // A pop frees a slot on the same edge, so a full FIFO may still push.
    assign do_push = push_i && (!full || do_pop);
    assign wptr_d  = wptr_q + {{AW{1'b0}}, do_push};
    assign rptr_d  = rptr_q + {{AW{1'b0}}, do_pop};
    assign head_o  = mem_q[rptr_q[AW-1:0]];

    assign full_next_o = (wptr_d[AW] != rptr_d[AW]) &&
                         (wptr_d[AW-1:0] == rptr_d[AW-1:0]);

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wptr_q[AW-1:0]] <= data_i;
        end
    end

endmodule

// File: rtl/out_channel_checker.sv
// Captures the executor's out-channel words, compares them in order
// against a fixed sequence and reports a sticky pass/fail verdict.
module out_channel_checker
    import out_check_pkg::*;
#(
    parameter int MemoryElementWidth = 12,
    parameter int NOut = 2,
    parameter logic [NOut*MemoryElementWidth-1:0] Expected = {12'd333, 12'd111},
    parameter int FifoDepth = 4,
    parameter int MaxSteps = 64
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          outValid,
    input  logic [MemoryElementWidth-1:0] outData,
    output logic                          outReady,
    input  logic                          progFinished,
    output logic                          finished,
    output logic                          success,
    output logic [recv_w(NOut)-1:0]       received,
    output logic [midx_w(NOut)-1:0]       mismatchIndex
);

    localparam int W  = MemoryElementWidth;
    localparam int RW = recv_w(NOut);
    localparam int MW = midx_w(NOut);
    localparam int SW = step_w(MaxSteps);

    state_e          state_q, state_d;
    logic [RW-1:0]   recv_q, recv_d;
    logic [MW-1:0]   midx_q, midx_d;
    logic [SW-1:0]   step_q, step_d;
    logic            fin_q, fin_d;
    logic            succ_q, succ_d;
    logic            rdy_q, rdy_d;

    logic            push, pop, empty, full_next;
    logic [W-1:0]    head, exp_w;
    logic            extra, mismatch, timeout;

    assign push = outValid && rdy_q;
    assign pop  = (state_q == RUN) && !empty;

    out_fifo #(
        .Width(W),
        .Depth(FifoDepth)
    ) u_fifo (
        .clk_i      (clock),
        .rst_ni     (reset),
        .push_i     (push),
        .pop_i      (pop),
        .data_i     (outData),
        .head_o     (head),
        .empty_o    (empty),
        .full_next_o(full_next)
    );

    always_comb begin
        exp_w = '0;
        for (int i = 0; i < NOut; i++) begin
            if (recv_q == RW'(i)) exp_w = Expected[i*W +: W];
        end
    end

    assign extra    = pop && (recv_q == RW'(NOut));
    assign mismatch = pop && !extra && (head != exp_w);
    assign timeout  = (step_q >= SW'(MaxSteps - 1));

    always_comb begin
        state_d = state_q;
        recv_d  = recv_q;
        midx_d  = midx_q;
        step_d  = step_q;
        if (state_q == RUN) begin
            if (step_q != SW'(MaxSteps)) step_d = step_q + 1'b1;
            if (pop && recv_q != RW'(NOut + 1)) recv_d = recv_q + 1'b1;
            if (mismatch) begin
                state_d = FAIL;
                midx_d  = MW'(recv_q);
            end else if (extra) begin
                state_d = FAIL;
                midx_d  = MW'(NOut);
            end else if (progFinished && empty) begin
                // Empty FIFO implies nothing was popped this cycle.
                if (recv_q == RW'(NOut)) begin
                    state_d = PASS;
                end else begin
                    state_d = FAIL;
                    midx_d  = MW'(recv_q);
                end
            end else if (timeout) begin
                state_d = FAIL;
                midx_d  = MW'(NOut);
            end
        end
        fin_d  = (state_d != RUN);
        succ_d = (state_d == PASS);
        rdy_d  = (state_d == RUN) && !full_next;
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q <= RUN;
            recv_q  <= '0;
            midx_q  <= '0;
            step_q  <= '0;
            fin_q   <= 1'b0;
            succ_q  <= 1'b0;
            rdy_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            recv_q  <= recv_d;
            midx_q  <= midx_d;
            step_q  <= step_d;
            fin_q   <= fin_d;
            succ_q  <= succ_d;
            rdy_q   <= rdy_d;
        end
    end

    assign outReady      = rdy_q;
    assign finished      = fin_q;
    assign success       = succ_q;
    assign received      = recv_q;
    assign mismatchIndex = midx_q;

endmodule

// File: tb/tb_out_channel_checker.sv
// Bench for out_channel_checker: vector table, scoreboard, corner sequences.
module tb_out_channel_checker;

    localparam int W    = 12;
    localparam int NOUT = 2;
    localparam int MAXS = 64;

    logic         clock = 1'b0;
    logic         reset = 1'b0;
    logic         outValid = 1'b0;
    logic [W-1:0] outData = '0;
    logic         progFinished = 1'b0;
    logic         outReady;
    logic         finished;
    logic         success;
    logic [1:0]   received;
    logic [1:0]   mismatchIndex;

    always #5 clock = ~clock;

    out_channel_checker #(
        .MemoryElementWidth(W),
        .NOut(NOUT),
        .Expected({12'd333, 12'd111}),
        .FifoDepth(4),
        .MaxSteps(MAXS)
    ) dut (
        .clock(clock),
        .reset(reset),
        .outValid(outValid),
        .outData(outData),
        .outReady(outReady),
        .progFinished(progFinished),
        .finished(finished),
        .success(success),
        .received(received),
        .mismatchIndex(mismatchIndex)
    );

    typedef struct {
        int           n;
        logic [W-1:0] w0, w1, w2;
        int           pf_dly;
        int           max_wait;
        logic         fin, suc;
        int           rcv, midx;
    } vec_t;

    typedef struct {
        int recv;
        bit bad;
    } sb_t;

    sb_t          sbq[$];
    logic [W-1:0] golden[NOUT] = '{12'd111, 12'd333};
    int           checks = 0;
    int           passed = 0;
    int           sent = 0;
    int           prev_recv = 0;

    task automatic chk(input string nm, input longint act, input longint exp);
        checks++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    endtask

    function automatic vec_t mk(input int n, input logic [W-1:0] a,
                                input logic [W-1:0] b, input logic [W-1:0] c,
                                input int pf, input int mw, input logic f,
                                input logic s, input int r, input int m);
        vec_t v;
        v.n = n; v.w0 = a; v.w1 = b; v.w2 = c;
        v.pf_dly = pf; v.max_wait = mw;
        v.fin = f; v.suc = s; v.rcv = r; v.midx = m;
        return v;
    endfunction

    // Expected compare outcome is queued at transfer time.
    task automatic sb_push(input logic [W-1:0] w);
        sb_t e;
        sent++;
        e.recv = sent;
        e.bad  = (sent > NOUT) ? 1'b1 : (w != golden[sent-1]);
        sbq.push_back(e);
    endtask

    always @(negedge clock) begin
        sb_t e;
        if (reset && int'(received) > prev_recv) begin
            if (sbq.size() == 0) begin
                checks++;
                $display("FAIL sb_underflow: got received %0d with no word queued",
                         received);
            end else begin
                e = sbq.pop_front();
                chk("sb_received", received, e.recv);
                chk("sb_verdict", {finished, success}, e.bad ? 2 : 0);
            end
        end
        prev_recv = int'(received);
    end

    task automatic do_reset();
        reset = 1'b0;
        outValid = 1'b0;
        progFinished = 1'b0;
        repeat (2) begin
            @(posedge clock);
            #1;
        end
        chk("rst_finished", finished, 0);
        chk("rst_success", success, 0);
        chk("rst_received", received, 0);
        chk("rst_midx", mismatchIndex, 0);
        chk("rst_ready", outReady, 0);
        sbq.delete();
        sent = 0;
        reset = 1'b1;
    endtask

    task automatic send(input logic [W-1:0] w);
        bit got = 1'b0;
        int n = 0;
        outValid = 1'b1;
        outData = w;
        while (!got && n < 20) begin
            @(negedge clock);
            got = outReady;
            @(posedge clock);
            #1;
            n++;
        end
        if (got) sb_push(w);
        else begin
            checks++;
            $display("FAIL send_timeout: got no outReady in %0d cycles expected 1", n);
        end
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int cyc = 0;
        do_reset();
        if (v.n > 0) send(v.w0);
        if (v.n > 1) send(v.w1);
        if (v.n > 2) send(v.w2);
        outValid = 1'b0;
        repeat (v.pf_dly) begin
            @(posedge clock);
            #1;
        end
        progFinished = 1'b1;
        while (!finished && cyc < 40) begin
            @(posedge clock);
            #1;
            cyc++;
        end
        checks++;
        if (cyc <= v.max_wait) passed++;
        else $display("FAIL v%0d_latency: got %0d cycles expected <= %0d",
                      idx, cyc, v.max_wait);
        chk($sformatf("v%0d_finished", idx), finished, v.fin);
        chk($sformatf("v%0d_success", idx), success, v.suc);
        chk($sformatf("v%0d_received", idx), received, v.rcv);
        chk($sformatf("v%0d_midx", idx), mismatchIndex, v.midx);
        chk($sformatf("v%0d_ready", idx), outReady, 0);
        progFinished = 1'b0;
    endtask

    initial begin
        vec_t         tbl[6];
        logic [W-1:0] bp_data[6];
        logic         bp_rdy[6];

        tbl[0] = mk(2, 12'd111, 12'd333, 12'd0, 2, 4, 1, 1, 2, 0);
        tbl[1] = mk(2, 12'd111, 12'd334, 12'd0, 2, 40, 1, 0, 2, 1);
        tbl[2] = mk(3, 12'd111, 12'd333, 12'd7, 2, 40, 1, 0, 3, 2);
        tbl[3] = mk(1, 12'd111, 12'd0, 12'd0, 2, 40, 1, 0, 1, 1);
        tbl[4] = mk(1, 12'd333, 12'd0, 12'd0, 2, 40, 1, 0, 1, 0);
        tbl[5] = mk(0, 12'd0, 12'd0, 12'd0, 0, 40, 1, 0, 0, 0);

        for (int i = 0; i < 6; i++) run_vec(tbl[i], i);

        // Continuous valid: ready holds while draining, drops on the extra word.
        bp_data = '{12'd111, 12'd333, 12'd7, 12'd7, 12'd7, 12'd7};
        bp_rdy  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        do_reset();
        @(posedge clock);
        #1;
        for (int k = 0; k < 6; k++) begin
            outValid = 1'b1;
            outData = bp_data[k];
            @(negedge clock);
            chk($sformatf("bp_ready%0d", k), outReady, bp_rdy[k]);
            if (outReady) sb_push(bp_data[k]);
            @(posedge clock);
            #1;
        end
        outValid = 1'b0;
        chk("bp_finished", finished, 1);
        chk("bp_success", success, 0);
        chk("bp_received", received, 3);
        chk("bp_midx", mismatchIndex, 2);

        // Silent executor: forced failure exactly at the step budget.
        do_reset();
        for (int k = 1; k < MAXS; k++) begin
            @(posedge clock);
            #1;
        end
        chk("to_early_finished", finished, 0);
        @(posedge clock);
        #1;
        chk("to_finished", finished, 1);
        chk("to_success", success, 0);
        chk("to_received", received, 0);
        chk("to_midx", mismatchIndex, 2);
        chk("to_ready", outReady, 0);

        // Reset after the first word, then a clean passing rerun.
        do_reset();
        send(12'd111);
        outValid = 1'b0;
        @(posedge clock);
        #1;
        chk("mid_received", received, 1);
        do_reset();
        run_vec(tbl[0], 6);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
